// File: rtl/led_spi_pkg.sv
// Shared definitions for the LED driver SPI engines (read engine now, write engine later).
package led_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_DATA,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic READ_BIT  = 1'b1;
    localparam int   CMD_BITS  = 8;
    localparam int   WORD_BITS = 16;

    // Phase timers are 8 bits wide, so timing parameters must stay within 1..256.
    typedef logic [7:0] tmr_t;

    function automatic logic [CMD_BITS-1:0] cmd_byte(input logic [6:0] reg_addr);
        return {READ_BIT, reg_addr};
    endfunction

endpackage

// File: rtl/led_spi_sclk_gen.sv
// SPI mode-0 clock generator: SCLK low for HALF_DIV cycles, then high for HALF_DIV.
// rise_en/fall_en are asserted on the clkin cycle before sclk visibly changes.
module led_spi_sclk_gen #(
    parameter int HALF_DIV = 12
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_en,
    output logic fall_en
);
    logic [7:0] cnt;
    logic       tc;

    assign tc      = en && (cnt == 8'd0);
    assign rise_en = tc && !sclk;
    assign fall_en = tc && sclk;

    // Reloading while disabled guarantees a full low half-period after enable.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 8'd0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= 8'(HALF_DIV - 1);
            sclk <= 1'b0;
        end else if (cnt == 8'd0) begin
            cnt  <= 8'(HALF_DIV - 1);
            sclk <= ~sclk;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

endmodule

// File: rtl/led_spi_rdback.sv
// Read engine for the LED driver: sends a read command byte over SPI mode 0 and
// captures len+1 16-bit words from miso.
//
// state | meaning
// IDLE  | waiting for start, cs_n high
// SETUP | cs_n low, CS_SETUP cycles before the command starts
// CMD   | shifting out the read command byte
// DATA  | capturing len+1 words, SCLK free-running
// HOLD  | SCLK parked low for CS_HOLD cycles before cs_n rises
// GAP   | cs_n high for GAP cycles before returning to IDLE
module led_spi_rdback
    import led_spi_pkg::*;
#(
    parameter int HALF_DIV = 12,
    parameter int CS_SETUP = 12,
    parameter int CS_HOLD  = 12,
    parameter int GAP      = 24
) (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  addr,
    input  logic [3:0]  len,
    output logic        busy,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    state_t                state, state_nxt;
    tmr_t                  tmr, tmr_nxt;
    logic [3:0]            bit_cnt, bit_nxt;
    logic [3:0]            word_cnt, word_nxt;
    logic [3:0]            len_q, len_nxt;
    logic [CMD_BITS-1:0]   cmd_sr, cmd_nxt;
    logic                  cs_n_q, cs_n_nxt;
    logic                  mosi_q, mosi_nxt;
    logic                  busy_q, busy_nxt;
    logic                  done_q, done_nxt;

    logic                  sclk_en, rise_en, fall_en;
    logic                  miso_s1, miso_s2;
    logic                  rise_d1, rise_d2, smp_en;
    logic [3:0]            smp_cnt;
    logic [WORD_BITS-2:0]  rx_sr;

    assign sclk_en  = (state == ST_CMD) || (state == ST_DATA);
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;

    led_spi_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk_gen (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .en      (sclk_en),
        .sclk    (spi_sclk),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tmr      <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            len_q    <= '0;
            cmd_sr   <= '0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            bit_cnt  <= bit_nxt;
            word_cnt <= word_nxt;
            len_q    <= len_nxt;
            cmd_sr   <= cmd_nxt;
            cs_n_q   <= cs_n_nxt;
            mosi_q   <= mosi_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        bit_nxt   = bit_cnt;
        word_nxt  = word_cnt;
        len_nxt   = len_q;
        cmd_nxt   = cmd_sr;
        cs_n_nxt  = cs_n_q;
        mosi_nxt  = mosi_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SETUP;
                    cmd_nxt   = cmd_byte(addr);
                    len_nxt   = len;
                    word_nxt  = '0;
                    tmr_nxt   = tmr_t'(CS_SETUP - 1);
                    cs_n_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tmr == '0) begin
                    state_nxt = ST_CMD;
                    mosi_nxt  = cmd_sr[CMD_BITS-1];
                    cmd_nxt   = {cmd_sr[CMD_BITS-2:0], 1'b0};
                    bit_nxt   = 4'(CMD_BITS - 1);
                end else begin
                    tmr_nxt = tmr - tmr_t'(1);
                end
            end
            ST_CMD: begin
                if (fall_en) begin
                    if (bit_cnt == 4'd0) begin
                        state_nxt = ST_DATA;
                        mosi_nxt  = 1'b0;
                        bit_nxt   = 4'(WORD_BITS - 1);
                    end else begin
                        bit_nxt  = bit_cnt - 4'd1;
                        mosi_nxt = cmd_sr[CMD_BITS-1];
                        cmd_nxt  = {cmd_sr[CMD_BITS-2:0], 1'b0};
                    end
                end
            end
            ST_DATA: begin
                // Word boundaries are tracked on SCLK falls; capture runs separately below.
                if (fall_en) begin
                    if (bit_cnt == 4'd0) begin
                        bit_nxt = 4'(WORD_BITS - 1);
                        if (word_cnt == len_q) begin
                            state_nxt = ST_HOLD;
                            tmr_nxt   = tmr_t'(CS_HOLD - 1);
                        end else begin
                            word_nxt = word_cnt + 4'd1;
                        end
                    end else begin
                        bit_nxt = bit_cnt - 4'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (tmr == '0) begin
                    state_nxt = ST_GAP;
                    cs_n_nxt  = 1'b1;
                    done_nxt  = 1'b1;
                    tmr_nxt   = tmr_t'(GAP - 1);
                end else begin
                    tmr_nxt = tmr - tmr_t'(1);
                end
            end
            ST_GAP: begin
                if (tmr == '0) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    tmr_nxt = tmr - tmr_t'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sample two cycles after the visible SCLK rise to absorb the synchroniser delay.
    assign smp_en = rise_d2 && (state == ST_DATA);

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            miso_s1  <= 1'b0;
            miso_s2  <= 1'b0;
            rise_d1  <= 1'b0;
            rise_d2  <= 1'b0;
            smp_cnt  <= '0;
            rx_sr    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            miso_s1  <= spi_miso;
            miso_s2  <= miso_s1;
            rise_d1  <= rise_en;
            rise_d2  <= rise_d1;
            rd_valid <= 1'b0;
            if (state == ST_IDLE) begin
                smp_cnt <= '0;
            end else if (smp_en) begin
                rx_sr   <= {rx_sr[WORD_BITS-3:0], miso_s2};
                smp_cnt <= smp_cnt + 4'd1;
                if (smp_cnt == 4'(WORD_BITS - 1)) begin
                    rd_data  <= {rx_sr, miso_s2};
                    rd_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_spi_rdback.sv
// Directed bench for led_spi_rdback: default-timing instance plus a HALF_DIV=2 instance.
module tb_led_spi_rdback;
    logic        clkin = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        f_start = 1'b0;
    logic [6:0]  addr = '0;
    logic [3:0]  len = '0;
    logic        spi_miso = 1'b0;
    logic        f_miso = 1'b0;

    logic        busy, rd_valid, done, spi_cs_n, spi_sclk, spi_mosi;
    logic [15:0] rd_data;
    logic        f_busy, f_rd_valid, f_done, f_cs_n, f_sclk, f_mosi;
    logic [15:0] f_rd_data;

    int n_vec = 0;
    int n_err = 0;

    initial forever #20 clkin = ~clkin;

    led_spi_rdback u_dut (
        .clkin(clkin), .rst_n(rst_n), .start(start), .addr(addr), .len(len),
        .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    led_spi_rdback #(.HALF_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .GAP(4)) u_fast (
        .clkin(clkin), .rst_n(rst_n), .start(f_start), .addr(addr), .len(len),
        .busy(f_busy), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .done(f_done),
        .spi_cs_n(f_cs_n), .spi_sclk(f_sclk), .spi_mosi(f_mosi), .spi_miso(f_miso)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Slave model and bus monitor for the default instance, sampled mid-cycle.
    logic [15:0] slv_words [16];
    logic [15:0] rv_log [64];
    logic [7:0]  mosi_byte = '0, last_byte = '0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    int cyc = 0, n_rise = 0, n_fall = 0, n_cs_rise = 0, rv_cnt = 0, done_cnt = 0;
    int done_bad = 0, mosi_viol = 0;
    int t_cs_fall = 0, t_cs_rise = 0, t_first_rise = 0, t_first_fall = 0, t_last_fall = 0;
    int last_rises = 0, last_setup = 0, last_half = 0, last_hold = 0, last_gap = 0;

    initial begin : mon
        forever begin
            @(negedge clkin);
            if (prev_cs && !spi_cs_n) begin
                last_gap  = cyc - t_cs_rise;
                t_cs_fall = cyc;
                n_rise    = 0;
                n_fall    = 0;
            end
            if (!prev_cs && spi_cs_n) begin
                t_cs_rise  = cyc;
                n_cs_rise++;
                last_rises = n_rise;
                last_byte  = mosi_byte;
                last_setup = t_first_rise - t_cs_fall;
                last_half  = t_first_fall - t_first_rise;
                last_hold  = cyc - t_last_fall;
                if (rst_n && !done) done_bad++;
            end
            if (!prev_sclk && spi_sclk) begin
                n_rise++;
                if (n_rise == 1) t_first_rise = cyc;
                if (n_rise <= 8) mosi_byte = {mosi_byte[6:0], spi_mosi};
            end
            if (prev_sclk && !spi_sclk) begin
                n_fall++;
                if (n_fall == 1) t_first_fall = cyc;
                t_last_fall = cyc;
                if (n_fall >= 8 && (n_fall - 8) / 16 < 16)
                    spi_miso = slv_words[(n_fall - 8) / 16][15 - (n_fall - 8) % 16];
            end
            if (spi_mosi && (spi_cs_n || n_fall >= 8)) mosi_viol++;
            if (rd_valid) begin
                if (rv_cnt < 64) rv_log[rv_cnt] = rd_data;
                rv_cnt++;
            end
            if (done) done_cnt++;
            prev_cs   = spi_cs_n;
            prev_sclk = spi_sclk;
            cyc++;
        end
    end

    // Fast-instance slave drives an alternating pattern starting with 1 on each data bit.
    logic [15:0] f_log [16];
    logic        f_prev_cs = 1'b1, f_prev_sclk = 1'b0;
    int f_nrise = 0, f_nfall = 0, f_rv_cnt = 0, f_last_rises = 0;

    initial begin : fmon
        forever begin
            @(negedge clkin);
            if (f_prev_cs && !f_cs_n) begin
                f_nrise = 0;
                f_nfall = 0;
            end
            if (!f_prev_cs && f_cs_n) f_last_rises = f_nrise;
            if (!f_prev_sclk && f_sclk) f_nrise++;
            if (f_prev_sclk && !f_sclk) begin
                f_nfall++;
                if (f_nfall >= 8) f_miso = ((f_nfall - 8) % 2 == 0) ? 1'b1 : 1'b0;
            end
            if (f_rd_valid) begin
                if (f_rv_cnt < 16) f_log[f_rv_cnt] = f_rd_data;
                f_rv_cnt++;
            end
            f_prev_cs   = f_cs_n;
            f_prev_sclk = f_sclk;
        end
    end

    task automatic pulse_start(input logic [6:0] a, input logic [3:0] l);
        @(negedge clkin);
        addr  = a;
        len   = l;
        start = 1'b1;
        @(negedge clkin);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 20000) begin
            @(negedge clkin);
            i++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin : stim
        int rv0, dn0, cr0, f0;
        for (int i = 0; i < 16; i++) slv_words[i] = 16'h0000;

        repeat (3) @(negedge clkin);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mosi_valid_done", 32'({spi_mosi, rd_valid, done}), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h0000);
        rst_n = 1'b1;

        // Single-word read
        slv_words[0] = 16'hA55A;
        rv0 = rv_cnt;
        dn0 = done_cnt;
        pulse_start(7'h15, 4'd0);
        chk("a_busy", 32'(busy), 32'd1);
        wait_idle("a");
        chk("a_mosi_byte", 32'(last_byte), 32'h95);
        chk("a_rv_count", rv_cnt - rv0, 1);
        chk("a_rd_data", 32'(rv_log[rv0]), 32'hA55A);
        chk("a_sclk_periods", last_rises, 24);
        chk("a_done_count", done_cnt - dn0, 1);
        chk("a_sclk_half", last_half, 12);
        chk("a_cs_fall_to_rise", last_setup, 24);
        chk("a_fall_to_cs_rise", last_hold, 12);

        // 16-word burst with start hammered throughout; the held start lands on first IDLE
        for (int i = 0; i < 16; i++) slv_words[i] = 16'(i);
        rv0 = rv_cnt;
        dn0 = done_cnt;
        cr0 = n_cs_rise;
        pulse_start(7'h2A, 4'd15);
        start = 1'b1;
        addr  = 7'h7F;
        len   = 4'd0;
        wait_idle("b");
        slv_words[0] = 16'h3CC3;
        chk("b_mosi_byte", 32'(last_byte), 32'hAA);
        chk("b_rv_count", rv_cnt - rv0, 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("b_word%0d", i), 32'(rv_log[rv0 + i]), 32'(i));
        chk("b_sclk_periods", last_rises, 264);
        chk("b_cs_rises", n_cs_rise - cr0, 1);
        chk("b_done_count", done_cnt - dn0, 1);
        rv0 = rv_cnt;
        @(negedge clkin);
        start = 1'b0;
        chk("c_accepted_first_idle", 32'(busy), 32'd1);
        wait_idle("c");
        chk("c_mosi_byte", 32'(last_byte), 32'hFF);
        chk("c_cs_high_gap", last_gap, 25);
        chk("c_rv_count", rv_cnt - rv0, 1);
        chk("c_rd_data", 32'(rv_log[rv0]), 32'h3CC3);
        chk("c_sclk_periods", last_rises, 24);

        // Reset at the 5th DATA SCLK rise
        slv_words[0] = 16'hFFFF;
        slv_words[1] = 16'hFFFF;
        pulse_start(7'h33, 4'd1);
        for (int i = 0; i < 2000 && n_rise != 13; i++) @(negedge clkin);
        chk("d_reach_data", n_rise, 13);
        rv0 = rv_cnt;
        dn0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("d_rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("d_rst_sclk", 32'(spi_sclk), 32'd0);
        chk("d_rst_busy", 32'(busy), 32'd0);
        chk("d_rst_rd_valid", 32'(rd_valid), 32'd0);
        repeat (4) @(negedge clkin);
        chk("d_no_rd_valid", rv_cnt - rv0, 0);
        chk("d_no_done", done_cnt - dn0, 0);
        slv_words[0] = 16'h1234;
        rv0   = rv_cnt;
        rst_n = 1'b1;
        addr  = 7'h01;
        len   = 4'd0;
        start = 1'b1;
        @(negedge clkin);
        start = 1'b0;
        chk("e_busy_first_cycle", 32'(busy), 32'd1);
        wait_idle("e");
        chk("e_mosi_byte", 32'(last_byte), 32'h81);
        chk("e_rv_count", rv_cnt - rv0, 1);
        chk("e_rd_data", 32'(rv_log[rv0]), 32'h1234);
        chk("e_sclk_periods", last_rises, 24);

        // HALF_DIV=2 instance, alternating miso
        f0 = f_rv_cnt;
        @(negedge clkin);
        addr    = 7'h40;
        len     = 4'd1;
        f_start = 1'b1;
        @(negedge clkin);
        f_start = 1'b0;
        chk("f_busy", 32'(f_busy), 32'd1);
        for (int i = 0; i < 2000 && f_busy; i++) @(negedge clkin);
        chk("f_idle", 32'(f_busy), 32'd0);
        chk("f_rv_count", f_rv_cnt - f0, 2);
        chk("f_word0", 32'(f_log[f0]), 32'hAAAA);
        chk("f_word1", 32'(f_log[f0 + 1]), 32'hAAAA);
        chk("f_sclk_periods", f_last_rises, 40);

        chk("done_with_cs_rise", done_bad, 0);
        chk("mosi_outside_cmd", mosi_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
